// File: rtl/synchro_down_timer.sv
// Loadable N-bit down-counter/timer with one-shot and auto-reload modes,
// pause/resume and an external count-enable tick for prescaler chaining.
module synchro_down_timer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         start,
    input  logic         stop,
    input  logic         auto_reload,
    input  logic         tick,
    output logic [N-1:0] q,
    output logic         busy,
    output logic         done,
    output logic         zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state, state_next;
    logic [N-1:0] count, count_next;
    logic [N-1:0] reload_reg, reload_next;
    logic         done_r, done_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            done_r     <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            reload_reg <= reload_next;
            done_r     <= done_next;
        end
    end

    // Priority below reset: load > stop > start > tick.
    always_comb begin
        state_next  = state;
        count_next  = count;
        reload_next = reload_reg;
        done_next   = 1'b0;

        if (load) begin
            count_next  = load_val;
            reload_next = load_val;
            state_next  = IDLE;
        end else begin
            unique case (state)
                IDLE, HOLD: begin
                    if (!stop && start && (count != '0))
                        state_next = RUN;
                end
                RUN: begin
                    if (stop) begin
                        state_next = HOLD;
                    end else if (tick) begin
                        if (count > ONE) begin
                            count_next = count - ONE;
                        end else if (count == ONE) begin
                            // Expiry: reload skips the zero cycle so the period is exactly reload ticks.
                            done_next = 1'b1;
                            if (auto_reload) begin
                                count_next = reload_reg;
                            end else begin
                                count_next = '0;
                                state_next = IDLE;
                            end
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign q    = count;
    assign busy = (state == RUN);
    assign done = done_r;
    assign zero = (count == '0);

endmodule

// File: tb/tb_synchro_down_timer.sv
// Self-checking bench for synchro_down_timer: directed scenarios plus a
// randomized run, all compared against a behavioural timer model.
module tb_synchro_down_timer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [N-1:0] load_val = '0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         auto_reload = 1'b0;
    logic         tick = 1'b0;
    logic [N-1:0] q;
    logic         busy;
    logic         done;
    logic         zero;

    int tests = 0;
    int fails = 0;

    // Behavioural model: remaining count, reload value, running/paused flags.
    int m_q = 0;
    int m_rl = 0;
    bit m_run = 0;
    bit m_done = 0;

    synchro_down_timer #(.N(N)) dut (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .auto_reload(auto_reload), .tick(tick),
        .q(q), .busy(busy), .done(done), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic cycle(input bit r, input bit ld, input int lv, input bit st,
                         input bit sp, input bit ar, input bit tk);
        reset = r; load = ld; load_val = lv[N-1:0]; start = st; stop = sp;
        auto_reload = ar; tick = tk;
        @(posedge clk);
        m_done = 0;
        if (r) begin
            m_q = 0; m_rl = 0; m_run = 0;
        end else if (ld) begin
            m_q = lv; m_rl = lv; m_run = 0;
        end else if (!m_run) begin
            if (!sp && st && m_q != 0) m_run = 1;
        end else if (sp) begin
            m_run = 0;
        end else if (tk) begin
            if (m_q >= 2) m_q = m_q - 1;
            else begin
                m_done = 1;
                if (ar) m_q = m_rl;
                else begin m_q = 0; m_run = 0; end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 1, 77, 1, 0, 1, 1);
        cycle(1, 0, 0, 1, 0, 0, 1);
        tests++; if (q !== 8'd0) begin fails++; $display("FAIL reset_q got %0d want 0", q); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %0b want 0", done); end
        tests++; if (zero !== 1'b1) begin fails++; $display("FAIL reset_zero got %0b want 1", zero); end
    endtask

    task automatic test_oneshot();
        cycle(0, 1, 5, 0, 0, 0, 1);
        tests++; if (q !== 8'd5 || busy !== 1'b0) begin fails++; $display("FAIL oneshot_load q=%0d busy=%0b want 5/0", q, busy); end
        cycle(0, 0, 0, 1, 0, 0, 1);
        tests++; if (q !== 8'd5 || busy !== 1'b1) begin fails++; $display("FAIL oneshot_start q=%0d busy=%0b want 5/1", q, busy); end
        for (int k = 1; k <= 5; k++) begin
            cycle(0, 0, 0, 0, 0, 0, 1);
            tests++;
            if (q !== 8'(5 - k) || done !== (k == 5) || busy !== (k != 5) || zero !== (k == 5)) begin
                fails++; $display("FAIL oneshot_step%0d q=%0d done=%0b busy=%0b want q=%0d", k, q, done, busy, 5 - k);
            end
        end
        cycle(0, 0, 0, 0, 0, 0, 1);
        tests++; if (done !== 1'b0 || zero !== 1'b1 || q !== 8'd0) begin fails++; $display("FAIL oneshot_after done=%0b zero=%0b q=%0d want 0/1/0", done, zero, q); end
    endtask

    task automatic test_auto_reload();
        cycle(0, 1, 3, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 0, 1, 1);
        for (int k = 1; k <= 9; k++) begin
            cycle(0, 0, 0, 0, 0, 1, 1);
            tests++;
            if (q !== 8'(3 - (k % 3)) || done !== (k % 3 == 0) || busy !== 1'b1) begin
                fails++; $display("FAIL autoreload_step%0d q=%0d done=%0b busy=%0b want q=%0d", k, q, done, busy, 3 - (k % 3));
            end
        end
        for (int k = 1; k <= 3; k++) cycle(0, 0, 0, 0, 0, 0, 1);
        tests++; if (q !== 8'd0 || busy !== 1'b0 || done !== 1'b1) begin fails++; $display("FAIL autoreload_off q=%0d busy=%0b done=%0b want 0/0/1", q, busy, done); end
    endtask

    task automatic test_pause();
        cycle(0, 1, 10, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 0, 0, 1);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 0, 0, 1);
        tests++; if (q !== 8'd6) begin fails++; $display("FAIL pause_pre q=%0d want 6", q); end
        cycle(0, 0, 0, 0, 1, 0, 1);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 0, 0, 0, 0, 1);
            tests++; if (q !== 8'd6 || busy !== 1'b0) begin fails++; $display("FAIL pause_hold%0d q=%0d busy=%0b want 6/0", k, q, busy); end
        end
        cycle(0, 0, 0, 1, 1, 0, 1);
        tests++; if (q !== 8'd6 || busy !== 1'b0) begin fails++; $display("FAIL pause_both q=%0d busy=%0b want 6/0", q, busy); end
        cycle(0, 0, 0, 1, 0, 0, 1);
        tests++; if (busy !== 1'b1 || q !== 8'd6) begin fails++; $display("FAIL pause_resume q=%0d busy=%0b want 6/1", q, busy); end
        for (int k = 1; k <= 2; k++) begin
            cycle(0, 0, 0, 1, 0, 0, 1);
            tests++; if (q !== 8'(6 - k)) begin fails++; $display("FAIL pause_count%0d q=%0d want %0d", k, q, 6 - k); end
        end
    endtask

    task automatic test_tick_gating();
        bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        int n = 0;
        cycle(0, 1, 4, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        foreach (pat[i]) begin
            cycle(0, 0, 0, 0, 0, 0, pat[i]);
            n += pat[i];
            tests++;
            if (q !== 8'(4 - n) || done !== (pat[i] && n == 4)) begin
                fails++; $display("FAIL tick_gate%0d q=%0d done=%0b want q=%0d", i, q, done, 4 - n);
            end
        end
    endtask

    task automatic test_boundaries();
        cycle(0, 1, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 0, 0, 1);
        cycle(0, 0, 0, 1, 0, 1, 1);
        tests++; if (busy !== 1'b0 || done !== 1'b0 || q !== 8'd0) begin fails++; $display("FAIL bound_zero busy=%0b done=%0b q=%0d want 0/0/0", busy, done, q); end
        cycle(0, 1, 255, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 0, 0, 1);
        for (int k = 1; k <= 256; k++) begin
            cycle(0, 0, 0, 0, 0, 0, 1);
            tests++;
            if (q !== 8'((k >= 255) ? 0 : 255 - k) || done !== (k == 255)) begin
                fails++; $display("FAIL bound_ff_step%0d q=%0d done=%0b", k, q, done);
            end
        end
        cycle(0, 1, 1, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        tests++; if (done !== 1'b1 || q !== 8'd0 || busy !== 1'b0) begin fails++; $display("FAIL bound_one done=%0b q=%0d busy=%0b want 1/0/0", done, q, busy); end
    endtask

    task automatic test_override();
        cycle(0, 1, 9, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        tests++; if (q !== 8'd7) begin fails++; $display("FAIL override_pre q=%0d want 7", q); end
        cycle(0, 1, 2, 1, 0, 0, 1);
        tests++; if (q !== 8'd2 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL override_load q=%0d busy=%0b done=%0b want 2/0/0", q, busy, done); end
        cycle(0, 0, 0, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 1);
        tests++; if (q !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL override_reset q=%0d busy=%0b done=%0b want 0/0/0", q, busy, done); end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r  = ($urandom_range(0, 199) == 0);
            bit ld = ($urandom_range(0, 29) == 0);
            int lv = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
            bit st = ($urandom_range(0, 4) == 0);
            bit sp = ($urandom_range(0, 14) == 0);
            bit ar = ($urandom_range(0, 1) == 1);
            bit tk = ($urandom_range(0, 3) != 0);
            cycle(r, ld, lv, st, sp, ar, tk);
            tests++;
            if (q !== 8'(m_q) || busy !== m_run || done !== m_done || zero !== (m_q == 0)) begin
                fails++;
                if (bad++ < 10) $display("FAIL random%0d q=%0d busy=%0b done=%0b zero=%0b want q=%0d busy=%0b done=%0b", i, q, busy, done, zero, m_q, m_run, m_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_auto_reload();
        test_pause();
        test_tick_gating();
        test_boundaries();
        test_override();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
